// File: rtl/delay_tap_reader.sv
`default_nettype none
// ============================================================================
// Module      : delay_tap_reader
// Description : Fetches the delayed sample at (write pointer - delay) on each
//               ADC tick through a ready/valid read port, scales it by an
//               unsigned Q8.8 gain with a 16-step shift-and-add multiplier,
//               and presents one saturated result to the effects mixer.
// Revision    : 1.0 - initial release
// ============================================================================
module delay_tap_reader #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 16,
    parameter int GAIN_FRAC = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              adc_clock,
    input  logic [ADDR_W-1:0] write_addr,
    input  logic [15:0]       delay_reverb,
    input  logic [15:0]       gain,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_raddr,
    output logic [DATA_W-1:0] sample_out,
    output logic              sample_valid,
    output logic              busy,
    output logic              overrun
);

    // 16-bit sample times 16-bit unsigned gain fits a 32-bit signed accumulator
    localparam int ACC_W = 32;
    localparam logic signed [ACC_W-1:0] C_SAT_MAX = ACC_W'((64'sd1 <<< (DATA_W - 1)) - 64'sd1);
    localparam logic signed [ACC_W-1:0] C_SAT_MIN = ~C_SAT_MAX;
    localparam logic [DATA_W-1:0] C_OUT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] C_OUT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_MULT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                    r_state;
    logic                      r_adc_prev;
    logic [15:0]               r_gain;
    logic signed [ACC_W-1:0]   r_mcand;
    logic signed [ACC_W-1:0]   r_acc;
    logic [3:0]                r_step;
    logic                      r_mem_re;
    logic [ADDR_W-1:0]         r_mem_raddr;
    logic [DATA_W-1:0]         r_sample_out;
    logic                      r_sample_valid;
    logic                      r_overrun;

    logic                      w_tick;
    logic signed [ACC_W-1:0]   w_addend;
    logic signed [ACC_W-1:0]   w_acc_next;
    logic signed [ACC_W-1:0]   w_res;
    logic [DATA_W-1:0]         w_sat;

    // Rising edge of the sample strobe; suppressed while reset is asserted
    assign w_tick = adc_clock && !r_adc_prev && !reset;

    // The multiplicand is pre-shifted each step, so bit 0 of the shifting gain
    // copy selects whether this step contributes
    assign w_addend   = r_gain[0] ? r_mcand : '0;
    assign w_acc_next = r_acc + w_addend;
    assign w_res      = w_acc_next >>> GAIN_FRAC;

    // Clamp the Q8.8-scaled product into the output sample range
    always_comb begin
        w_sat = w_res[DATA_W-1:0];
        if (w_res > C_SAT_MAX) begin
            w_sat = C_OUT_MAX;
        end else if (w_res < C_SAT_MIN) begin
            w_sat = C_OUT_MIN;
        end
    end

    // Strobe edge register, updated every cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_adc_prev <= 1'b0;
        end else begin
            r_adc_prev <= adc_clock;
        end
    end

    // Read / multiply / present sequencer with registered outputs.
    // The result is registered on the last multiply step so that the DONE
    // cycle is the one in which sample_valid is visible.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_gain         <= '0;
            r_mcand        <= '0;
            r_acc          <= '0;
            r_step         <= '0;
            r_mem_re       <= 1'b0;
            r_mem_raddr    <= '0;
            r_sample_out   <= '0;
            r_sample_valid <= 1'b0;
            r_overrun      <= 1'b0;
        end else begin
            r_sample_valid <= 1'b0;
            r_overrun      <= w_tick && (r_state != S_IDLE);
            case (r_state)
                S_IDLE: begin
                    if (w_tick) begin
                        r_mem_raddr <= write_addr - ADDR_W'(delay_reverb);
                        r_gain      <= gain;
                        r_mem_re    <= 1'b1;
                        r_state     <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (r_mem_re && mem_ready) begin
                        r_mcand  <= {{(ACC_W-DATA_W){mem_rdata[DATA_W-1]}}, mem_rdata};
                        r_acc    <= '0;
                        r_step   <= '0;
                        r_mem_re <= 1'b0;
                        r_state  <= S_MULT;
                    end
                end
                S_MULT: begin
                    r_acc   <= w_acc_next;
                    r_mcand <= r_mcand <<< 1;
                    r_gain  <= r_gain >> 1;
                    r_step  <= r_step + 4'd1;
                    if (r_step == 4'd15) begin
                        r_sample_out   <= w_sat;
                        r_sample_valid <= 1'b1;
                        r_state        <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign mem_re       = r_mem_re;
    assign mem_raddr    = r_mem_raddr;
    assign sample_out   = r_sample_out;
    assign sample_valid = r_sample_valid;
    assign overrun      = r_overrun;
    assign busy         = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: doc/delay_tap_reader.md
Name: delay_tap_reader

Overview:
Read-side counterpart to the sample memory controller's write path. On each ADC sample tick it fetches the delayed sample at (write pointer − delay) from sample memory using a ready/valid read handshake. It scales the fetched sample by a Q8.8 gain with a sequential 16-step shift-and-add multiplier, then presents one saturated 16-bit result to the effects mixer.

Parameters:
DATA_W, 16, sample width (two's-complement)
ADDR_W, 16, sample memory address width
GAIN_FRAC, 8, fractional bits of gain (0x0100 = unity)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
adc_clock  input  1  sample strobe level, synchronous to clk; rising edge = tick
write_addr  input  ADDR_W  current write pointer of memory controller
delay_reverb  input  16  tap delay in samples
gain  input  16  unsigned Q8.8 tap gain
mem_ready  input  1  memory read-data-valid/accept
mem_rdata  input  DATA_W  read data, valid when mem_re && mem_ready
mem_re  output  1  read request
mem_raddr  output  ADDR_W  read address
sample_out  output  DATA_W  scaled tap sample
sample_valid  output  1  one-cycle strobe, sample_out updated
busy  output  1  high whenever FSM not in IDLE
overrun  output  1  one-cycle pulse, tick dropped

Behaviour:
- Reset (sync, active-high; takes priority over all other activity):
  - All outputs 0; FSM to IDLE.
  - adc_clock edge register cleared.
  - Applies mid-transaction too: mem_re drops the next cycle and no sample_valid is issued.
- Tick detection:
  - Tick when adc_prev==0 && adc_clock==1; adc_prev updates every cycle.
  - A tick is never generated in the reset cycle.
- FSM states: IDLE, REQ, MULT, DONE.
- IDLE:
  - On tick, latch mem_raddr = (write_addr − delay_reverb) mod 2^ADDR_W and latch gain.
  - Go to REQ.
- REQ:
  - mem_re=1; mem_raddr held stable.
  - On the cycle mem_re && mem_ready, capture mem_rdata, clear the accumulator, go to MULT.
  - mem_re deasserts the following cycle.
  - No timeout; the FSM waits indefinitely for mem_ready.
- MULT: 16 cycles, step i = 0..15.
  - If gain_latched[i], add (sign-extended sample << i) into a 32-bit signed accumulator.
  - After step 15, go to DONE.
- DONE:
  - Compute res = acc >>> GAIN_FRAC (arithmetic shift, truncation toward −inf).
  - Saturate: if res > 32767 then 0x7FFF; if res < −32768 then 0x8000; otherwise low 16 bits.
  - Register the result into sample_out, pulse sample_valid for 1 cycle, return to IDLE.
  - sample_out holds its value until the next DONE.
- Latency: tick cycle T → mem_re high at T+1.
  - With mem_ready at T+1: MULT spans T+2..T+17 and sample_valid is at T+18.
  - Each wait cycle on mem_ready adds 1.
- Overrun: a tick when the FSM is not in IDLE is dropped and overrun pulses 1 cycle.
  - The in-flight transaction is unaffected.
  - A tick arriving in the same cycle DONE returns to IDLE is also dropped, since the state is DONE.
- Wrap-around: address subtraction is modulo 2^16; delay 0 reads write_addr itself.
- gain, delay_reverb and write_addr changes after the tick do not affect the in-flight sample.
- gain==0: result 0, sample_valid still issued.

Test Plan:
1. Unity gain: gain=0x0100, delay_reverb=5, write_addr=0x0010, mem_ready=1, mem_rdata=0x1234 → mem_raddr=0x000B at T+1; sample_out=0x1234, sample_valid at T+18 only.
2. Wrap/scale: write_addr=0x0002, delay_reverb=5, mem_rdata=0xF000, gain=0x0080 → mem_raddr=0xFFFD; sample_out=0xF800.
3. Saturation: mem_rdata=0x4000, gain=0x0400 → 0x7FFF; then mem_rdata=0xC000, gain=0x0400 → 0x8000.
4. Wait states: mem_ready low 3 cycles after request → mem_re and mem_raddr stable throughout; capture on 4th request cycle; sample_valid at T+21.
5. Overrun: second adc_clock rising edge during MULT → overrun=1 for exactly 1 cycle; exactly one sample_valid; mem_re not re-asserted until next tick.
6. Reset mid-MULT: assert reset at T+8 for 1 cycle → busy, mem_re, sample_valid, sample_out all 0 next cycle; next tick gives a normal result at tick+18.
